div_sequencer: RTL and testbench
================================

# div_sequencer

Sequencer and HI/LO register owner for the multicycle divider in the CPU datapath. It sits between the control unit and the divider. On a DIV request it latches the operands and screens them for divide-by-zero. It then drives the divider's operation enable for exactly 32 cycles, captures the quotient and remainder into the architectural LO/HI registers, and reports completion or a divide-by-zero exception to the control unit. It also services direct HI/LO writes (MTHI/MTLO) and provides HI/LO read data.

## Interface
Parameters: none; every width is fixed at 32 bits.
- clk  in  1  system clock; everything is sampled on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  DIV request from the control unit, sampled in IDLE
- rs_val  in  32  dividend
- rt_val  in  32  divisor
- hi_wr  in  1  MTHI write strobe
- lo_wr  in  1  MTLO write strobe
- wr_data  in  32  data for MTHI/MTLO
- div_op  out  1  operation enable to the divider (registered)
- div_dividend  out  32  latched dividend to the divider
- div_divisor  out  32  latched divisor to the divider
- div_lo_in  in  32  quotient from the divider
- div_hi_in  in  32  remainder from the divider
- divby0_in  in  1  divide-by-zero flag from the divider
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_zero_exc  out  1  one-cycle exception pulse
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

## Operation
- States: IDLE, RUN, WB, EXC. Encoding is free.
- IDLE:
  - div_op = 0. This guarantees the divider has its internal bit counter re-initialised before any run.
  - If start is high: latch rs_val into div_dividend and rt_val into div_divisor.
  - If rt_val == 0, go to EXC. Otherwise clear the 5-bit counter cnt and go to RUN.
- RUN:
  - div_op = 1.
  - cnt increments on every edge. On the edge where cnt == 31 (the 32nd RUN edge), go to WB.
  - div_dividend and div_divisor stay constant for the whole run, because the divider re-reads the dividend sign at the end.
  - If divby0_in is sampled high in RUN (defensive check only): go to EXC and leave HI/LO unchanged.
- WB:
  - div_op = 0.
  - On the edge, capture hi <= div_hi_in and lo <= div_lo_in, set done for the next cycle, and go to IDLE.
- EXC:
  - div_op = 0.
  - On the edge, set div_zero_exc for the next cycle and go to IDLE. HI/LO are not modified.
- MTHI/MTLO:
  - hi_wr or lo_wr in IDLE writes wr_data into HI or LO on that edge.
  - Writes while busy = 1 are ignored and dropped.
  - hi_wr and lo_wr together write both registers.
- start while busy is ignored; there is no queueing.
- start and hi_wr/lo_wr on the same IDLE edge: the write takes effect now, and the DIV result overwrites it later.
- Signed semantics are defined by the divider. This block passes operands and results through unmodified.

## Timing
- Reset values:
  - state IDLE, cnt 0
  - div_op, busy, done, div_zero_exc all 0
  - hi, lo, div_dividend, div_divisor all 0x00000000
- Reset asserted mid-operation: on the next edge the block returns to IDLE with div_op = 0 and every reset value above restored. A partial divider result is never captured.
- Normal division, with edge 0 being the one that samples start:
  - busy rises after edge 0.
  - div_op is high between edges 0 and 32, giving exactly 32 enabled edges to the divider.
  - WB edge is edge 33.
  - done = 1 and the new hi/lo are visible in the cycle after edge 33.
  - busy falls together with done.
  - Total start-to-done latency: 34 cycles.
- Divide by zero:
  - div_zero_exc = 1 in the cycle after edge 1; busy = 1 for one cycle only.
  - div_op is never asserted.
- done and div_zero_exc are never both high.
- Back-to-back requests: the earliest next start is accepted in the same cycle as done, which is IDLE. Latency is again 34 cycles.

## Test plan
- After reset: start with rs_val = 100, rt_val = 7 -> div_op high for exactly 32 cycles, then done at cycle 34, lo = 14, hi = 2, busy low with done.
- rt_val = 0, rs_val = 55, with HI/LO preloaded to 0xAAAA0000 / 0x0000BBBB via MTHI/MTLO -> div_zero_exc one-cycle pulse at cycle 2, div_op never high, HI/LO unchanged, done never high.
- Start 0xFFFFFF9C / 7 (-100/7) against the divider model -> hi/lo equal the model's div_hi/div_lo; div_dividend stable through all of RUN.
- During RUN, pulse hi_wr with 0x12345678 and pulse start with new operands -> both ignored; result is from the original operands; hi afterwards equals the division remainder.
- Reset asserted at cycle 10 of RUN -> next cycle: IDLE, div_op = 0, hi = lo = 0, no done; then a fresh 100/7 completes correctly in 34 cycles.
- Two back-to-back divisions (100/7, then 81/9 with start in the done cycle) -> second done 34 cycles after the first; lo = 9, hi = 0.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequencer for the multicycle divider: operand latch, divide-by-zero screen,
// 32-cycle run control, and ownership of the architectural HI/LO registers.
module div_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        hi_wr,
   input  logic        lo_wr,
   input  logic [31:0] wr_data,
   output logic        div_op,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic [31:0] div_lo_in,
   input  logic [31:0] div_hi_in,
   input  logic        divby0_in,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, WB, EXC} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        div_op_q, div_op_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        exc_q, exc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_op_d = 1'b0;
      done_d   = 1'b0;
      exc_d    = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;

      case (state_q)
         IDLE: begin
            if (hi_wr) hi_d = wr_data;
            if (lo_wr) lo_d = wr_data;
            if (start) begin
               dvd_d = rs_val;
               dvs_d = rt_val;
               if (rt_val == '0) begin
                  state_d = EXC;
               end else begin
                  cnt_d    = '0;
                  div_op_d = 1'b1;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q + 5'd1;
            // A divider-side zero flag aborts the run before any result is captured.
            if (divby0_in) begin
               state_d = EXC;
            end else if (cnt_q == 5'd31) begin
               state_d = WB;
            end else begin
               div_op_d = 1'b1;
            end
         end
         WB: begin
            hi_d    = div_hi_in;
            lo_d    = div_lo_in;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         EXC: begin
            exc_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_op_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         exc_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_op_q <= div_op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         exc_q    <= exc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
      end
   end

   assign div_op       = div_op_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign div_zero_exc = exc_q;
   assign hi           = hi_q;
   assign lo           = lo_q;
   assign div_dividend = dvd_q;
   assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: emulated 32-cycle divider, operation-age reference
// model compared every cycle, directed literal scenarios and random traffic.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, hi_wr, lo_wr, divby0_in;
   logic [31:0] rs_val, rt_val, wr_data, div_lo_in, div_hi_in;
   logic        div_op, busy, done, div_zero_exc;
   logic [31:0] div_dividend, div_divisor, hi, lo;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   div_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .rs_val(rs_val), .rt_val(rt_val),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data), .div_op(div_op),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_lo_in(div_lo_in), .div_hi_in(div_hi_in), .divby0_in(divby0_in),
      .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo)
   );

   // Returns {remainder, quotient} with truncating signed semantics.
   function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Emulated divider: result valid only after exactly 32 enabled edges.
   int dcnt;
   logic [63:0] dres;
   always @(posedge clk) begin
      if (reset || !div_op) dcnt <= 0;
      else if (dcnt < 40) dcnt <= dcnt + 1;
   end
   always_comb begin
      dres = sdiv(div_dividend, div_divisor);
      if (dcnt == 32) begin
         div_hi_in = dres[63:32];
         div_lo_in = dres[31:0];
      end else begin
         div_hi_in = 32'hDEAD_BEEF;
         div_lo_in = 32'hBAAD_F00D;
      end
   end

   // Reference model: age counts edges since the accepting edge, -1 when idle.
   int          age = -1;
   bit          m_zero, m_done, m_exc;
   logic [31:0] m_dvd, m_dvs, m_hi, m_lo;
   always @(posedge clk) begin
      if (reset) begin
         age = -1; m_zero = 0; m_done = 0; m_exc = 0;
         m_dvd = 0; m_dvs = 0; m_hi = 0; m_lo = 0;
      end else begin
         m_done = 0;
         m_exc  = 0;
         if (age < 0) begin
            if (hi_wr) m_hi = wr_data;
            if (lo_wr) m_lo = wr_data;
            if (start) begin
               m_dvd = rs_val; m_dvs = rt_val;
               m_zero = (rt_val == 32'd0);
               age = 0;
            end
         end else if (m_zero) begin
            m_exc = 1; age = -1;
         end else if (age <= 31 && divby0_in) begin
            m_zero = 1; age = 0;
         end else begin
            age++;
            if (age == 33) begin
               {m_hi, m_lo} = sdiv(m_dvd, m_dvs);
               m_done = 1;
               age = -1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("div_op", {31'd0, div_op}, {31'd0, (!m_zero && age >= 0 && age <= 31)});
         check("busy", {31'd0, busy}, {31'd0, (age >= 0)});
         check("done", {31'd0, done}, {31'd0, m_done});
         check("div_zero_exc", {31'd0, div_zero_exc}, {31'd0, m_exc});
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("div_dividend", div_dividend, m_dvd);
         check("div_divisor", div_divisor, m_dvs);
      end
   end

   task automatic wait_end(output int lat, output int ops, output bit dn, output bit ex);
      lat = 0; ops = 0; dn = 0; ex = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         lat = i;
         if (i == 1) start = 1'b0;
         if (div_op) ops++;
         if (done) dn = 1;
         if (div_zero_exc) ex = 1;
         if (done || div_zero_exc) break;
      end
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int ops, output bit dn, output bit ex);
      start = 1'b1; rs_val = a; rt_val = b;
      wait_end(lat, ops, dn, ex);
   endtask

   int lat, ops;
   bit dn, ex;

   initial begin
      reset = 1; start = 0; hi_wr = 0; lo_wr = 0; wr_data = 0;
      rs_val = 0; rt_val = 0; divby0_in = 0;
      repeat (2) @(negedge clk);
      checking = 1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 0;
      @(negedge clk);

      // 100 / 7
      run_div(32'd100, 32'd7, lat, ops, dn, ex);
      check("t1_latency", lat, 34);
      check("t1_op_cycles", ops, 32);
      check("t1_done", {31'd0, dn}, 1);
      check("t1_lo", lo, 32'd14);
      check("t1_hi", hi, 32'd2);
      check("t1_busy_with_done", {31'd0, busy}, 0);

      // MTHI/MTLO preload then divide by zero
      hi_wr = 1; wr_data = 32'hAAAA_0000;
      @(negedge clk);
      hi_wr = 0; lo_wr = 1; wr_data = 32'h0000_BBBB;
      @(negedge clk);
      lo_wr = 0;
      run_div(32'd55, 32'd0, lat, ops, dn, ex);
      check("t2_latency", lat, 2);
      check("t2_exc", {31'd0, ex}, 1);
      check("t2_no_done", {31'd0, dn}, 0);
      check("t2_no_op", ops, 0);
      check("t2_hi", hi, 32'hAAAA_0000);
      check("t2_lo", lo, 32'h0000_BBBB);
      @(negedge clk);
      check("t2_exc_pulse", {31'd0, div_zero_exc}, 0);

      // -100 / 7
      run_div(32'hFFFF_FF9C, 32'd7, lat, ops, dn, ex);
      check("t3_lo", lo, 32'hFFFF_FFF2);
      check("t3_hi", hi, 32'hFFFF_FFFE);

      // MTHI and start during RUN are dropped
      start = 1; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      hi_wr = 1; wr_data = 32'h1234_5678; start = 1; rs_val = 32'd999; rt_val = 32'd3;
      @(negedge clk);
      hi_wr = 0; start = 0;
      wait_end(lat, ops, dn, ex);
      check("t4_done", {31'd0, dn}, 1);
      check("t4_hi", hi, 32'd2);
      check("t4_lo", lo, 32'd14);

      // reset in the middle of RUN
      start = 1; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 0;
      repeat (10) @(negedge clk);
      reset = 1;
      @(negedge clk);
      check("t5_div_op", {31'd0, div_op}, 0);
      check("t5_busy", {31'd0, busy}, 0);
      check("t5_done", {31'd0, done}, 0);
      check("t5_hi", hi, 32'd0);
      check("t5_lo", lo, 32'd0);
      reset = 0;
      run_div(32'd100, 32'd7, lat, ops, dn, ex);
      check("t5_latency", lat, 34);
      check("t5_lo_after", lo, 32'd14);

      // back-to-back, second start in the done cycle
      run_div(32'd100, 32'd7, lat, ops, dn, ex);
      run_div(32'd81, 32'd9, lat, ops, dn, ex);
      check("t6_latency", lat, 34);
      check("t6_lo", lo, 32'd9);
      check("t6_hi", hi, 32'd0);

      // divider-side zero flag during RUN
      start = 1; rs_val = 32'd20; rt_val = 32'd3;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      divby0_in = 1;
      @(negedge clk);
      divby0_in = 0;
      wait_end(lat, ops, dn, ex);
      check("t7_exc", {31'd0, ex}, 1);
      check("t7_no_done", {31'd0, dn}, 0);
      check("t7_lo", lo, 32'd9);

      // random traffic
      repeat (3000) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 999) == 0);
         start     = ($urandom_range(0, 9) == 0);
         rs_val    = $urandom;
         case ($urandom_range(0, 3))
            0:       rt_val = 32'd0;
            1:       rt_val = $urandom_range(1, 20);
            default: rt_val = $urandom;
         endcase
         hi_wr     = ($urandom_range(0, 11) == 0);
         lo_wr     = ($urandom_range(0, 11) == 0);
         wr_data   = $urandom;
         divby0_in = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      reset = 0; start = 0; hi_wr = 0; lo_wr = 0; divby0_in = 0;
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
